// File: rtl/des_final_perm_stream.sv
// DES output stage: IP^-1 on R16||L16 into a DEPTH-block FIFO, streamed as 8 bytes with valid/ready/last.
// Byte 0 follows an accept into an empty FIFO by one cycle; in_ready uses registered count only; DES_FP_BLOCK_CNT_EN adds blk_cnt.
module des_final_perm_stream #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
`ifdef DES_FP_BLOCK_CNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [63:0]   p;
  logic [63:0]   f;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    idx;
  logic [63:0]   head;
  logic [7:0]    head_byte;
  logic          push;
  logic          pop;
  logic          byte_hs;

  // Halves swap here: R16 occupies DES bits 1..32 of the preoutput.
  assign p = {in_l, in_r};

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign f[8*r+2*c]   = p[39-r+8*c];
      assign f[8*r+2*c+1] = p[7-r+8*c];
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_last  = out_valid && (idx == 3'd7);
  assign push      = in_valid && in_ready;
  assign byte_hs   = out_valid && out_ready;
  assign pop       = byte_hs && (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (byte_hs) begin
        idx <= idx + 3'd1;
      end
    end
  end

  // DES bit 8*idx+1 is the byte MSB, so the slice is bit-reversed on the way out.
  assign head      = mem[rd_ptr];
  assign head_byte = head[{idx, 3'b000} +: 8];

  always_comb begin
    out_byte = '0;
    if (out_valid) begin
      for (int j = 0; j < 8; j++) begin
        out_byte[7-j] = head_byte[j];
      end
    end
  end

`ifdef DES_FP_BLOCK_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (pop) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_des_final_perm_stream.sv
// Bench for des_final_perm_stream: directed steps plus random blocks checked against a table-driven DES model.
module tb_des_final_perm_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_l;
  logic [31:0] in_r;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
`ifdef DES_FP_BLOCK_CNT_EN
  logic [15:0] blk_cnt;
`endif

  des_final_perm_stream #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_l     (in_l),
    .in_r     (in_r),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_byte (out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
`ifdef DES_FP_BLOCK_CNT_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Standard DES tables, 1-based bit numbers, bit 1 = leftmost.
  int fp_t [64] = '{40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
                    38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
                    36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
                    34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
  int ip_t [64] = '{58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
                    62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
                    57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
                    61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};

  int          n_assert = 0;
  int          n_fail   = 0;
  int          bcount   = 0;
  int          exp_blk  = 0;
  logic        in_acc   = 1'b0;
  logic [63:0] cur_exp  = '0;
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  // Blocks in the bench are held as hex words: DES bit n is word bit 64-n.
  function automatic logic [63:0] permute(input logic [63:0] v, input bit use_fp);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      o[63-i] = v[64 - (use_fp ? fp_t[i] : ip_t[i])];
    end
    return o;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[i] = v[31-i];
    return o;
  endfunction

  function automatic logic [63:0] model(input logic [31:0] l, input logic [31:0] r);
    return permute({r, l}, 1'b1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_blk(input logic [31:0] l, input logic [31:0] r, input logic [63:0] exp);
    in_l    = rev32(l);
    in_r    = rev32(r);
    cur_exp = exp;
  endtask

  // One clock: sample at the falling edge, score handshakes, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) begin
      got_q.push_back(out_byte);
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {56'd0, out_byte}, 64'hx);
      end else begin
        check("byte", {56'd0, out_byte}, {56'd0, exp_q.pop_front()});
        check("last", {63'd0, out_last}, {63'd0, (bcount == 7)});
        if (bcount == 7) exp_blk++;
        bcount = (bcount + 1) % 8;
      end
    end
    in_acc = in_valid && in_ready;
    if (in_acc) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(cur_exp[63-8*k -: 8]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one();
    int b;
    b = 0;
    in_valid = 1'b1;
    tick();
    while (!in_acc && b < 200) begin
      tick();
      b++;
    end
    check("send_accept", {63'd0, in_acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int b;
    b = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && b < 400) begin
      tick();
      b++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  logic [7:0]  vec1 [8];
  logic [63:0] x;
  logic [63:0] ipx;
  logic [7:0]  hold_b;
  int          sent;

  initial begin
    vec1 = '{8'h85, 8'hE8, 8'h13, 8'h54, 8'h0F, 8'h0A, 8'hB4, 8'h05};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_l = '0; in_r = '0;
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_byte",  {56'd0, out_byte},  64'd0);
    check("rst_out_last",  {63'd0, out_last},  64'd0);
    tick(); tick();
    rst = 1'b0;

    // Standard vector, with first-byte latency.
    got_q.delete();
    out_ready = 1'b1;
    set_blk(32'h43423234, 32'h0A4CD995, model(32'h43423234, 32'h0A4CD995));
    in_valid = 1'b1;
    tick();
    check("vec1_accept", {63'd0, in_acc}, 64'd1);
    in_valid = 1'b0;
    check("vec1_lat_valid", {63'd0, out_valid}, 64'd1);
    check("vec1_lat_byte0", {56'd0, out_byte}, 64'h85);
    drain("vec1_drain");
    check("vec1_count", 64'(got_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) check("vec1_const", {56'd0, got_q[k]}, {56'd0, vec1[k]});
`ifdef DES_FP_BLOCK_CNT_EN
    check("vec1_blk_cnt", {48'd0, blk_cnt}, 64'd1);
`endif

    // Random blocks with random stalls: even ones as given, odd ones fed pre-swapped so output must equal x.
    sent = 0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        x   = {$urandom(), $urandom()};
        ipx = permute(x, 1'b0);
        if (sent % 2 == 0) set_blk(ipx[63:32], ipx[31:0], model(ipx[63:32], ipx[31:0]));
        else               set_blk(ipx[31:0], ipx[63:32], x);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (in_acc) begin
        in_valid = 1'b0;
        sent++;
      end
      if (sent == 1000 && exp_q.size() == 0) break;
    end
    in_valid = 1'b0;
    check("rand_sent", 64'(sent), 64'd1000);
    drain("rand_drain");

    // Backpressure at byte index 4.
    got_q.delete();
    out_ready = 1'b1;
    set_blk($urandom(), $urandom(), 64'd0);
    cur_exp = model(rev32(in_l), rev32(in_r));
    send_one();
    for (int k = 0; k < 4; k++) tick();
    out_ready = 1'b0;
    hold_b = cur_exp[31:24];
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_byte",  {56'd0, out_byte},  {56'd0, hold_b});
      check("bp_last",  {63'd0, out_last},  64'd0);
    end
    drain("bp_drain");
    check("bp_count", 64'(got_q.size()), 64'd8);

    // Fill to DEPTH with the sink stalled, then drain.
    got_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_blk($urandom(), $urandom(), 64'd0);
      cur_exp = model(rev32(in_l), rev32(in_r));
      send_one();
    end
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    set_blk($urandom(), $urandom(), 64'd0);
    cur_exp = model(rev32(in_l), rev32(in_r));
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("full_held", {63'd0, in_acc}, 64'd0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("full_pop_hold", {63'd0, in_acc}, 64'd0);
    end
    tick();
    check("full_reopen", {63'd0, in_acc}, 64'd1);
    in_valid = 1'b0;
    drain("full_drain");
    check("full_count", 64'(got_q.size()), 64'd24);

    // Continuous streaming: no bubbles.
    out_ready = 1'b1;
    set_blk($urandom(), $urandom(), 64'd0);
    cur_exp = model(rev32(in_l), rev32(in_r));
    in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (in_acc) begin
        set_blk($urandom(), $urandom(), 64'd0);
        cur_exp = model(rev32(in_l), rev32(in_r));
      end
      check("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    drain("stream_drain");

    // Asynchronous reset at byte 3 of block 0 with block 1 queued.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_blk($urandom(), $urandom(), 64'd0);
      cur_exp = model(rev32(in_l), rev32(in_r));
      send_one();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready",  {63'd0, in_ready},  64'd1);
    check("arst_out_byte",  {56'd0, out_byte},  64'd0);
    check("arst_out_last",  {63'd0, out_last},  64'd0);
`ifdef DES_FP_BLOCK_CNT_EN
    check("arst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
`endif
    exp_q.delete();
    bcount  = 0;
    exp_blk = 0;
    tick();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    set_blk($urandom(), $urandom(), 64'd0);
    cur_exp = model(rev32(in_l), rev32(in_r));
    send_one();
    check("arst_new_byte0", {56'd0, out_byte}, {56'd0, cur_exp[63:56]});
    drain("arst_drain");
    check("arst_idle", {63'd0, out_valid}, 64'd0);
`ifdef DES_FP_BLOCK_CNT_EN
    check("final_blk_cnt", {48'd0, blk_cnt}, 64'(exp_blk));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/des_final_perm_stream.md
Name: des_final_perm_stream

Overview:
- Output end of the DES datapath: the matching inverse of the initial permutation.
- Accepts the round-16 halves (L16, R16) with a valid/ready handshake and forms the preoutput R16||L16.
- Applies the final permutation (IP^-1), buffers up to two permuted blocks and emits them as an 8-byte ciphertext stream with valid/ready/last.

Parameters:
- DEPTH, 2, number of permuted 64-bit blocks buffered; legal values 1..4.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_l, input, 32, L16 half from round 16.
- in_r, input, 32, R16 half from round 16.
- in_valid, input, 1, in_l/in_r hold a valid block.
- in_ready, output, 1, block accepted on in_valid&&in_ready.
- out_byte, output, 8, ciphertext byte.
- out_valid, output, 1, out_byte valid.
- out_ready, input, 1, sink accepts byte on out_valid&&out_ready.
- out_last, output, 1, marks byte 7 of a block.
- blk_cnt, output, 16, completed-block count (only with DES_FP_BLOCK_CNT_EN).

Behaviour:
- Bit convention: vector index k is DES bit k+1, so index 0 is the leftmost (first) bit of a block or half.
- Preoutput p[31:0] = in_r[31:0] and p[63:32] = in_l[31:0]; the halves are swapped, R16 first.
- Final permutation, for r = 0..7 and c = 0..3:
  - f[8r+2c] = p[39-r+8c]
  - f[8r+2c+1] = p[7-r+8c]
  - Examples: f[0]=p[39], f[1]=p[7], f[6]=p[63], f[7]=p[31], f[63]=p[24].
- The permutation is evaluated combinationally at the input and written into the buffer on accept. Raw halves are never stored.
- Buffer: a DEPTH-entry circular FIFO with wr_ptr, rd_ptr and count registers.
  - in_ready = (count < DEPTH), taken from registered count only.
  - No combinational path from out_ready to in_ready.
- Serializer: a byte index 0..7 over the FIFO head entry.
  - out_valid = (count != 0).
  - out_byte[7-j] = head[8*idx + j] for j = 0..7, so DES bit 8*idx+1 lands on the byte MSB.
  - out_last = out_valid && idx == 7.
  - On a byte handshake idx increments. On the byte-7 handshake idx wraps to 0, the head is popped (rd_ptr wraps modulo DEPTH) and count decrements.
- Latency: a block accepted in cycle N into an empty FIFO presents byte 0 in cycle N+1. With out_ready held high, bytes 0..7 appear in cycles N+1..N+8.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
  - This is possible only when count < DEPTH before the cycle.
  - At count == DEPTH, in_ready stays 0 during the popping cycle and rises the next cycle.
- Backpressure: with out_ready low, out_byte, out_last and idx hold stable while out_valid is high.
- Reset (async, any time, including mid-block):
  - count=0, wr_ptr=0, rd_ptr=0, idx=0.
  - out_valid=0, out_last=0, out_byte=0, in_ready=1 (combinational from count=0 once reset is asserted).
  - Any partially sent block is discarded.
  - blk_cnt=0 when present.

Optional Feature:
- Macro: DES_FP_BLOCK_CNT_EN.
- Defined: blk_cnt is present. It increments on every out_last handshake and wraps 0xFFFF -> 0x0000. Reset value is 0.
- Undefined: the blk_cnt port and its register are absent. All other behaviour is identical.

Test Plan:
1. Standard vector: in_l=0x43423234, in_r=0x0A4CD995, written in DES bit order (first hex digit = indices 0..3, index 0 = digit MSB); out_ready=1 -> bytes 85 E8 13 54 0F 0A B4 05, out_last on 05 only, blk_cnt=1.
2. Inverse check: random 64-bit x -> apply the reference IP model, split into in_l=ip[31:0] and in_r=ip[63:32], feed through -> reassembled output bits equal x with the halves swapped per DES; run 1000 vectors.
3. Backpressure: out_ready low for 3 cycles at idx=4 -> out_byte and out_last stable, no byte lost or duplicated.
4. Full and drain with DEPTH=2 and out_ready=0:
   - Push 2 blocks -> in_ready=0; a third block is held off.
   - Raise out_ready -> in_ready returns 1 the cycle after block 0's byte-7 handshake.
   - 24 bytes emerge in order.
5. Streaming: in_valid=1 and out_ready=1 continuously -> one byte per cycle with no bubbles.
6. Reset mid-operation:
   - Assert rst at byte 3 of block 0 with block 1 buffered -> out_valid=0, in_ready=1 and blk_cnt=0, all asynchronously.
   - A new block after release emits from byte 0.
